avalon_deadtime: RTL and testbench
==================================

Name: avalon_deadtime

Overview:
Avalon-MM slave that sits directly downstream of the PWM controller. It converts each single-ended pwm_out channel into a complementary high-side/low-side gate pair with a programmable dead time on both edges. It also latches an external active-low fault input and forces all gates off until software clears the fault. Outputs drive half-bridge gate drivers.

Parameters:
CHANNELS, 4, number of PWM inputs / gate pairs (1..16)
DT_WIDTH, 8, dead-time counter and register width
DT_RESET, 4, reset value of both dead-time registers

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
chipselect  in  1  Avalon slave select
address  in  3  register word address
write  in  1  Avalon write strobe
writedata  in  32  write data
read  in  1  Avalon read strobe
readdata  out  32  read data, combinational, zero wait states
irq  out  1  fault interrupt, registered
pwm_in  in  CHANNELS  PWM from upstream controller, clk-synchronous
fault_n  in  1  external fault, active-low, asynchronous
gate_hi  out  CHANNELS  high-side gate enables, registered
gate_lo  out  CHANNELS  low-side gate enables, registered

Behaviour:
- Register map: 0 DT_RISE [DT_WIDTH-1:0] RW; 1 DT_FALL RW; 2 CTRL RW (bit0 ENA, bit1 IRQ_ENA); 3 STATUS (bit0 FAULT_LAT, W1C; bit1 FAULT_NOW = synced fault level, RO); 4 GATES RO = {gate_lo, gate_hi} zero-extended. Other addresses read 0; writes to them are ignored. readdata = 0 when not (chipselect & read).
- Reset: DT_RISE = DT_RESET, DT_FALL = DT_RESET, CTRL = 0, FAULT_LAT = 0, sync flops = 1 (no fault), irq = 0, all channels in OFF, gate_hi = gate_lo = 0.
- pwm_in is registered once (in_q). fault_n passes through a 2-FF synchronizer (flt_s, 1 = fault).
- Per-channel Moore FSM. Gates decode from state: OFF 00, LO lo=1, DT_LH 00, HI hi=1, DT_HL 00. gate_hi and gate_lo are never 1 together.
- Per-channel counter cnt [DT_WIDTH-1:0] clears on entry to DT_LH or DT_HL and increments while in those states.
- kill = !ENA | FAULT_LAT | flt_s. kill in any state -> OFF on the next edge. kill has priority over all other transitions.
- OFF and !kill -> DT_HL, cnt = 0.
- LO: in_q = 1 -> DT_LH.
- DT_LH: in_q = 0 -> LO (a pulse shorter than the dead time is swallowed). Otherwise cnt >= DT_RISE -> HI.
- HI: in_q = 0 -> DT_HL.
- DT_HL: in_q = 1 -> HI. Otherwise cnt >= DT_FALL -> LO.
- Dead interval is DT+1 clocks; DT = 0 still gives a 1-clock gap. The >= compare makes a mid-interval register rewrite to a smaller value exit on the next edge.
- Latency: pwm_in edge to gate change is 2 clk edges, plus the dead interval on turn-on.
- Fault: flt_s = 1 sets FAULT_LAT on the same edge all FSMs go to OFF. Pin to gates-off is 3 edges.
- FAULT_LAT clear: write 1 to STATUS bit0. The clear is ignored while flt_s = 1. Set wins over a simultaneous clear.
- irq <= FAULT_LAT & IRQ_ENA, registered, so it follows FAULT_LAT by 1 edge.
- Clearing ENA mid-pulse drops gates to 00 on the next edge. Re-enabling always passes through DT_HL.
- Synchronous reset asserted mid-operation forces reset values on the next edge regardless of bus activity.

Test Plan:
- Reset, write DT_RISE=3, DT_FALL=5, CTRL=1; drive pwm_in ch0 high for 20 clk -> gate_lo0 falls 2 edges after the rise, 4 clk of 00, then gate_hi0=1. On the fall, hi0 drops, 6 clk of 00, then lo0=1.
- DT_RISE=10, 4-clk pwm_in pulse -> gate_hi0 never asserts; gate_lo0 returns to 1 with no dead gap after the pulse.
- All channels toggling with random duty for 10k clk with DT=0/1/7 -> gate_hi & gate_lo == 0 on every cycle; gap >= DT+1 on every turn-on.
- Pulse fault_n low for 1 clk with IRQ_ENA=1 -> all gates 0 by the 3rd edge, FAULT_LAT=1, irq=1 one edge later. W1C while fault_n low -> no clear. W1C after release -> irq=0, gates resume via a DT_HL gap.
- Read all addresses after reset -> 4,4,0,0,0; address 5..7 -> 0. GATES readback matches pins during operation.
- While in DT_HL with cnt=6 of 10, write DT_FALL=2 -> LO on the next edge.

Source files
------------

// File: rtl/avalon_deadtime.sv
// Avalon-MM dead-time generator: turns each PWM channel into a complementary
// high/low gate pair with programmable edge dead time and a latched fault kill.
module avalon_deadtime #(
    parameter int CHANNELS = 4,
    parameter int DT_WIDTH = 8,
    parameter int DT_RESET = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic [2:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic                irq,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic                fault_n,
    output logic [CHANNELS-1:0] gate_hi,
    output logic [CHANNELS-1:0] gate_lo
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LO    = 3'd1,
        S_DT_LH = 3'd2,
        S_HI    = 3'd3,
        S_DT_HL = 3'd4
    } state_t;

    logic [DT_WIDTH-1:0] r_dt_rise;
    logic [DT_WIDTH-1:0] r_dt_fall;
    logic                r_ena;
    logic                r_irq_ena;
    logic                r_fault_lat;
    logic                r_flt_sync1;
    logic                r_flt_sync2;
    logic                r_irq;
    logic [CHANNELS-1:0] r_in_q;
    logic [CHANNELS-1:0] r_gate_hi;
    logic [CHANNELS-1:0] r_gate_lo;
    state_t              r_state    [CHANNELS];
    state_t              w_next     [CHANNELS];
    logic [DT_WIDTH-1:0] r_cnt      [CHANNELS];
    logic [DT_WIDTH-1:0] w_cnt_next [CHANNELS];

    logic        w_wr;
    logic        w_flt_s;
    logic        w_kill;
    logic        w_w1c;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Synchroniser flops hold the fault_n level, so 0 in the second stage means fault.
    assign w_flt_s  = ~r_flt_sync2;
    assign w_wr     = chipselect & write;
    assign w_w1c    = w_wr & (address == 3'd3) & writedata[0];
    assign w_kill   = ~r_ena | r_fault_lat | w_flt_s;
    assign w_unused = ^writedata;

    // Control/status registers, fault latch, synchronisers and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dt_rise   <= DT_WIDTH'(DT_RESET);
            r_dt_fall   <= DT_WIDTH'(DT_RESET);
            r_ena       <= 1'b0;
            r_irq_ena   <= 1'b0;
            r_fault_lat <= 1'b0;
            r_flt_sync1 <= 1'b1;
            r_flt_sync2 <= 1'b1;
            r_irq       <= 1'b0;
            r_in_q      <= '0;
        end else begin
            if (w_wr) begin
                case (address)
                    3'd0:    r_dt_rise <= writedata[DT_WIDTH-1:0];
                    3'd1:    r_dt_fall <= writedata[DT_WIDTH-1:0];
                    3'd2: begin
                        r_ena     <= writedata[0];
                        r_irq_ena <= writedata[1];
                    end
                    default: ;
                endcase
            end
            // A live fault both sets the latch and blocks software from clearing it.
            if (w_flt_s) begin
                r_fault_lat <= 1'b1;
            end else if (w_w1c) begin
                r_fault_lat <= 1'b0;
            end
            r_irq       <= r_fault_lat & r_irq_ena;
            r_flt_sync1 <= fault_n;
            r_flt_sync2 <= r_flt_sync1;
            r_in_q      <= pwm_in;
        end
    end

    // Per-channel next state and dead-time counter.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_next[i]     = r_state[i];
            w_cnt_next[i] = r_cnt[i];
            if (w_kill) begin
                w_next[i] = S_OFF;
            end else begin
                case (r_state[i])
                    S_OFF:   w_next[i] = S_DT_HL;
                    S_LO:    w_next[i] = r_in_q[i] ? S_DT_LH : S_LO;
                    S_DT_LH: begin
                        if (!r_in_q[i])                w_next[i] = S_LO;
                        else if (r_cnt[i] >= r_dt_rise) w_next[i] = S_HI;
                        else                           w_next[i] = S_DT_LH;
                    end
                    S_HI:    w_next[i] = r_in_q[i] ? S_HI : S_DT_HL;
                    S_DT_HL: begin
                        if (r_in_q[i])                 w_next[i] = S_HI;
                        else if (r_cnt[i] >= r_dt_fall) w_next[i] = S_LO;
                        else                           w_next[i] = S_DT_HL;
                    end
                    default: w_next[i] = S_OFF;
                endcase
            end
            if ((w_next[i] == S_DT_LH || w_next[i] == S_DT_HL) && (w_next[i] != r_state[i])) begin
                w_cnt_next[i] = '0;
            end else if (r_state[i] == S_DT_LH || r_state[i] == S_DT_HL) begin
                w_cnt_next[i] = r_cnt[i] + 1'b1;
            end else begin
                w_cnt_next[i] = r_cnt[i];
            end
        end
    end

    // State, counter and gate registers; gates are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= S_OFF;
                r_cnt[i]   <= '0;
            end
            r_gate_hi <= '0;
            r_gate_lo <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i]   <= w_next[i];
                r_cnt[i]     <= w_cnt_next[i];
                r_gate_hi[i] <= (w_next[i] == S_HI);
                r_gate_lo[i] <= (w_next[i] == S_LO);
            end
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        w_rdata = 32'd0;
        if (chipselect && read) begin
            case (address)
                3'd0:    w_rdata = 32'(r_dt_rise);
                3'd1:    w_rdata = 32'(r_dt_fall);
                3'd2:    w_rdata = {30'd0, r_irq_ena, r_ena};
                3'd3:    w_rdata = {30'd0, w_flt_s, r_fault_lat};
                3'd4:    w_rdata = 32'({r_gate_lo, r_gate_hi});
                default: w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

    assign readdata = w_rdata;
    assign irq      = r_irq;
    assign gate_hi  = r_gate_hi;
    assign gate_lo  = r_gate_lo;

endmodule

// File: tb/tb_avalon_deadtime.sv
// Randomised self-checking bench for avalon_deadtime against a side/settle model.
module tb_avalon_deadtime;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect;
    logic [2:0]    address;
    logic          write;
    logic [31:0]   writedata;
    logic          read;
    logic [31:0]   readdata;
    logic          irq;
    logic [CH-1:0] pwm_in;
    logic          fault_n;
    logic [CH-1:0] gate_hi;
    logic [CH-1:0] gate_lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    avalon_deadtime #(.CHANNELS(CH), .DT_WIDTH(8), .DT_RESET(4)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .read(read), .readdata(readdata),
        .irq(irq), .pwm_in(pwm_in), .fault_n(fault_n),
        .gate_hi(gate_hi), .gate_lo(gate_lo)
    );

    // Model: each channel is off, or aims at a side and is settled once the gap has elapsed.
    logic [7:0]    m_rise, m_fall;
    logic          m_ena, m_irq_ena, m_lat, m_irq, m_s1, m_s2;
    logic [CH-1:0] m_in_q, m_hi, m_lo;
    bit            m_off [CH];
    bit            m_side [CH];
    bit            m_settled [CH];
    int            m_elapsed [CH];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rise = 8'd4; m_fall = 8'd4; m_ena = 1'b0; m_irq_ena = 1'b0;
        m_lat = 1'b0; m_irq = 1'b0; m_s1 = 1'b1; m_s2 = 1'b1; m_in_q = '0;
        for (int c = 0; c < CH; c++) begin
            m_off[c] = 1'b1; m_side[c] = 1'b0; m_settled[c] = 1'b0; m_elapsed[c] = 0;
        end
    endtask

    task automatic model_gates();
        for (int c = 0; c < CH; c++) begin
            m_hi[c] = !m_off[c] && m_settled[c] && m_side[c];
            m_lo[c] = !m_off[c] && m_settled[c] && !m_side[c];
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_rise};
            3'd1:    return {24'd0, m_fall};
            3'd2:    return {30'd0, m_irq_ena, m_ena};
            3'd3:    return {30'd0, !m_s2, m_lat};
            3'd4:    return 32'({m_lo, m_hi});
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        bit kill;
        bit w1c;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            kill = !m_ena || m_lat || !m_s2;
            for (int c = 0; c < CH; c++) begin
                if (kill) begin
                    m_off[c] = 1'b1;
                end else if (m_off[c]) begin
                    m_off[c] = 1'b0; m_side[c] = 1'b0; m_settled[c] = 1'b0; m_elapsed[c] = 0;
                end else if (m_settled[c]) begin
                    if (m_in_q[c] != m_side[c]) begin
                        m_side[c] = m_in_q[c]; m_settled[c] = 1'b0; m_elapsed[c] = 0;
                    end
                end else if (m_in_q[c] != m_side[c]) begin
                    m_side[c] = m_in_q[c]; m_settled[c] = 1'b1;
                end else if (m_elapsed[c] >= int'(m_side[c] ? m_rise : m_fall)) begin
                    m_settled[c] = 1'b1;
                end else begin
                    m_elapsed[c]++;
                end
            end
            w1c   = chipselect && write && (address == 3'd3) && writedata[0];
            m_irq = m_lat && m_irq_ena;
            if (!m_s2) m_lat = 1'b1;
            else if (w1c) m_lat = 1'b0;
            m_s2   = m_s1;
            m_s1   = fault_n;
            m_in_q = pwm_in;
            if (chipselect && write) begin
                case (address)
                    3'd0: m_rise = writedata[7:0];
                    3'd1: m_fall = writedata[7:0];
                    3'd2: begin m_ena = writedata[0]; m_irq_ena = writedata[1]; end
                    default: ;
                endcase
            end
        end
        model_gates();
        #1;
        check("gate_hi", 32'(gate_hi), 32'(m_hi));
        check("gate_lo", 32'(gate_lo), 32'(m_lo));
        check("irq", 32'(irq), 32'(m_irq));
        check("overlap", 32'(gate_hi & gate_lo), 32'd0);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        chipselect = 1'b1; read = 1'b1; address = a;
        #1;
        check($sformatf("rd%0d", a), readdata, exp_read(a));
        chipselect = 1'b0; read = 1'b0;
        #1;
        check("rd_idle", readdata, 32'd0);
    endtask

    initial begin
        int n;
        int dts [3] = '{0, 1, 7};
        bit hi_seen;

        reset = 1'b1; chipselect = 1'b0; address = 3'd0; write = 1'b0;
        writedata = 32'd0; read = 1'b0; pwm_in = '0; fault_n = 1'b1;
        model_reset();
        model_gates();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) bus_read(3'(a));
        check("rst_dt_rise", readdata, 32'd0);

        // Basic rise/fall dead time
        bus_write(3'd0, 32'd3);
        bus_write(3'd1, 32'd5);
        bus_write(3'd2, 32'd1);
        repeat (12) tick();
        check("settled_lo", 32'(gate_lo), 32'hF);
        pwm_in = 4'b0001;
        n = 0;
        while (gate_lo[0] && n < 10) begin tick(); n++; end
        check("lat_rise", n, 2);
        n = 0;
        while (!gate_hi[0] && n < 40) begin tick(); n++; end
        check("gap_rise", n, 4);
        repeat (14) tick();
        bus_read(3'd4);
        pwm_in = 4'b0000;
        n = 0;
        while (gate_hi[0] && n < 10) begin tick(); n++; end
        check("lat_fall", n, 2);
        n = 0;
        while (!gate_lo[0] && n < 40) begin tick(); n++; end
        check("gap_fall", n, 6);

        // Short pulse is swallowed
        bus_write(3'd0, 32'd10);
        repeat (5) tick();
        pwm_in = 4'b0001;
        hi_seen = 1'b0; n = 0;
        for (int k = 0; k < 24; k++) begin
            if (k == 4) pwm_in = 4'b0000;
            tick();
            if (gate_hi[0]) hi_seen = 1'b1;
            if (!gate_hi[0] && !gate_lo[0]) n++;
        end
        check("swallow_hi", 32'(hi_seen), 32'd0);
        check("swallow_gap", n, 4);

        // Random toggling at several dead times
        foreach (dts[j]) begin
            bus_write(3'd0, 32'(dts[j]));
            bus_write(3'd1, 32'(dts[j]));
            repeat (3000) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 5) == 0) pwm_in[c] = ~pwm_in[c];
                tick();
                if ($urandom_range(0, 63) == 0) bus_read(3'($urandom_range(0, 7)));
            end
        end

        // Fault latch, irq and clear
        pwm_in = 4'b0000;
        bus_write(3'd2, 32'd3);
        repeat (15) tick();
        fault_n = 1'b0;
        n = 0;
        while ((gate_hi | gate_lo) != 4'b0000 && n < 10) begin
            tick(); n++;
            if (n == 1) fault_n = 1'b1;
        end
        check("fault_lat", n, 3);
        bus_read(3'd3);
        tick();
        check("irq_set", 32'(irq), 32'd1);
        fault_n = 1'b0;
        repeat (3) tick();
        bus_write(3'd3, 32'd1);
        bus_read(3'd3);
        tick();
        check("irq_hold", 32'(irq), 32'd1);
        fault_n = 1'b1;
        repeat (3) tick();
        bus_write(3'd3, 32'd1);
        tick();
        check("irq_clr", 32'(irq), 32'd0);
        n = 0;
        while (gate_lo != 4'hF && n < 40) begin tick(); n++; end
        check("resume_gap", n, 8);

        // Shrinking DT_FALL mid-interval
        bus_write(3'd1, 32'd10);
        bus_write(3'd0, 32'd2);
        pwm_in = 4'b0001;
        n = 0;
        while (!gate_hi[0] && n < 40) begin tick(); n++; end
        repeat (3) tick();
        pwm_in = 4'b0000;
        n = 0;
        while (gate_hi[0] && n < 10) begin tick(); n++; end
        repeat (6) tick();
        bus_write(3'd1, 32'd2);
        check("shrink_wait", 32'(gate_lo[0]), 32'd0);
        tick();
        check("shrink_exit", 32'(gate_lo[0]), 32'd1);

        // Reset mid-operation with a write in flight
        pwm_in = 4'b1010;
        repeat (10) tick();
        reset = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'd99;
        tick();
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        check("rst_gates", 32'({gate_lo, gate_hi}), 32'd0);
        for (int a = 0; a < 8; a++) bus_read(3'(a));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
